// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle ops plus iterative shift-add multiply.
// Define ALU_FLAGS_EN to register {N,Z,C,V} with each result.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_ld;

  logic             accept;
  logic             last;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_sum;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;

  assign accept  = in_valid && in_ready;
  assign last    = (cnt_q == SW'(WIDTH-1));
  assign shamt   = src_b[SW-1:0];
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    unique case (ALUControl)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_MUL:  alu_res = '0;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRL:  alu_res = src_a >> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    res_ld   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (ALUControl == OP_MUL) begin
            state_d  = BUSY;
            mcand_d  = src_a;
            mplier_d = src_b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d = DONE;
            res_d   = alu_res;
            res_ld  = 1'b1;
          end
        end
      end
      BUSY: begin
        // one multiplier bit per cycle, fixed WIDTH iterations
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SW'(1);
        if (last) begin
          state_d = DONE;
          res_d   = mul_sum;
          res_ld  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [3:0] flags_q, flags_d;
  logic       c_d, v_d;

  always_comb begin
    c_d = 1'b0;
    v_d = 1'b0;
    // carry/overflow only apply to add/sub, which finish from IDLE
    if (state_q == IDLE && ALUControl == OP_ADD) begin
      c_d = (alu_res < src_a);
      v_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
            (alu_res[WIDTH-1] != src_a[WIDTH-1]);
    end else if (state_q == IDLE && ALUControl == OP_SUB) begin
      c_d = (src_a >= src_b);
      v_d = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
            (alu_res[WIDTH-1] != src_a[WIDTH-1]);
    end
    flags_d = flags_q;
    if (res_ld) flags_d = {res_d[WIDTH-1], (res_d == '0), c_d, v_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized bench for alu_exec_unit against a latency-level reference model.
// Flag expectations follow ALU_FLAGS_EN when it is defined.
module tb_alu_exec_unit;
  localparam int W = 32;
  localparam longint SMAX = (longint'(1) <<< (W-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W-1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   alu_ctl = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUControl(alu_ctl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] fx(input logic [3:0] f);
`ifdef ALU_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  function automatic logic [W-1:0] ref_res(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return p[W-1:0];
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [W:0]   s;
    longint       sa, sb, ss;
    logic         c, v;
    r  = ref_res(op, a, b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = 1'b0;
    v  = 1'b0;
    if (op == 3'd0) begin
      s  = {1'b0, a} + {1'b0, b};
      c  = s[W];
      ss = sa + sb;
      v  = (ss > SMAX) || (ss < SMIN);
    end else if (op == 3'd1) begin
      c  = (a >= b);
      ss = sa - sb;
      v  = (ss > SMAX) || (ss < SMIN);
    end
    return fx({r[W-1], (r == '0), c, v});
  endfunction

  // reference: idle / waiting-for-mul / holding-result
  int           m_wait = 0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_pend = '0;
  logic [3:0]   m_flags = '0;
  logic [3:0]   m_pflags = '0;
  logic         m_ready;
  assign m_ready = !m_valid && (m_wait == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait  = 0;
      m_valid = 1'b0;
      m_res   = '0;
      m_flags = '0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1;
        m_res   = m_pend;
        m_flags = m_pflags;
      end
    end else if (in_valid) begin
      if (alu_ctl == 3'd2) begin
        m_wait   = W;
        m_pend   = ref_res(alu_ctl, src_a, src_b);
        m_pflags = ref_flags(alu_ctl, src_a, src_b);
      end else begin
        m_valid = 1'b1;
        m_res   = ref_res(alu_ctl, src_a, src_b);
        m_flags = ref_flags(alu_ctl, src_a, src_b);
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, m_valid);
    chk("result", result, m_res);
    chk("flags", flags, m_flags);
  end

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold,
                        output logic [W-1:0] r, output logic [3:0] f,
                        output int lat, output bit rdy_seen);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_before_op", in_ready, 1);
    alu_ctl   = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctl  = 3'($urandom);
    src_a    = $urandom;
    src_b    = $urandom;
    lat      = 0;
    rdy_seen = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (in_ready) rdy_seen = 1'b1;
      if (out_valid) break;
    end
    chk("valid_seen", out_valid, 1);
    r = result;
    f = flags;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        in_valid = 1'b1;
        alu_ctl  = 3'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
        @(negedge clk);
        chk("hold_result", result, r);
        chk("hold_flags", flags, f);
        chk("hold_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_consume", in_ready, 1);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0] r;
  logic [3:0]   f;
  int           lat;
  bit           rs;

  initial begin
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'h1, 0, r, f, lat, rs);
    chk("add_wrap_res", r, 32'h0);
    chk("add_wrap_flags", f, fx(4'b0110));
    chk("add_wrap_lat", lat, 1);

    run_op(3'd0, 32'h7FFF_FFFF, 32'h1, 0, r, f, lat, rs);
    chk("add_ovf_res", r, 32'h8000_0000);
    chk("add_ovf_flags", f, fx(4'b1001));

    run_op(3'd1, 32'd5, 32'd7, 0, r, f, lat, rs);
    chk("sub_res", r, 32'hFFFF_FFFE);
    chk("sub_flags", f, fx(4'b1000));

    run_op(3'd2, 32'd1234, 32'd5678, 0, r, f, lat, rs);
    chk("mul_res", r, 32'h006A_E9BC);
    chk("mul_flags", f, fx(4'b0000));
    chk("mul_lat", lat, 33);
    chk("mul_ready_low", rs, 0);

    run_op(3'd5, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5, r, f, lat, rs);
    chk("xor_res", r, 32'hAAAA_AAAA);
    chk("xor_flags", f, fx(4'b1000));

    run_op(3'd6, 32'h1, 32'h25, 0, r, f, lat, rs);
    chk("sll_res", r, 32'h20);
    run_op(3'd7, 32'h8000_0000, 32'd31, 0, r, f, lat, rs);
    chk("srl_res", r, 32'h1);

    alu_ctl  = 3'd2;
    src_a    = 32'd999;
    src_b    = 32'd777;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, 0, r, f, lat, rs);
    chk("post_rst_res", r, 32'd7);
    chk("post_rst_lat", lat, 1);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 2) == 0;
      out_ready = ($urandom % 4) != 0;
      alu_ctl   = 3'($urandom);
      src_a     = pick();
      src_b     = pick();
      if ($urandom % 500 == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
